// File: rtl/mult_dispatcher.sv
// Operand feeder for the 4x4 sequential multiplier: buffers operand pairs,
// issues one start pulse per pair, waits out the multiplier's busy/ready
// cycle and parks each product in a single valid/ack result register.
module mult_dispatcher #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               op_ready,
    output logic [WIDTH-1:0]   mult_in_1,
    output logic [WIDTH-1:0]   mult_in_2,
    output logic               mult_start,
    input  logic               mult_ready,
    input  logic [2*WIDTH-1:0] mult_out,
    output logic [2*WIDTH-1:0] res_data,
    output logic               res_valid,
    input  logic               res_ack,
    output logic               busy,
    output logic [7:0]         op_count
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned PROD_W  = 2 * WIDTH;
    localparam int unsigned ENTRY_W = 2 * WIDTH;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [ENTRY_W-1:0] fifo_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  mult_in_1_q, mult_in_1_d;
    logic [WIDTH-1:0]  mult_in_2_q, mult_in_2_d;
    logic              mult_start_q, mult_start_d;
    logic [PROD_W-1:0] res_data_q, res_data_d;
    logic              res_valid_q, res_valid_d;
    logic [7:0]        op_count_q, op_count_d;

    logic               full_c;
    logic               push_c;
    logic               pop_c;
    logic               capture_c;
    logic [ENTRY_W-1:0] head_c;

    // Handshake decodes shared by the FIFO and the FSM.
    always_comb begin
        full_c    = (count_q == CNT_W'(DEPTH));
        push_c    = op_valid && !full_c;
        pop_c     = (state_q == S_IDLE) && (count_q != '0) && (!res_valid_q || res_ack);
        capture_c = (state_q == S_WAIT_DONE) && mult_ready;
        head_c    = fifo_q[rd_ptr_q];
    end

    // Operand storage; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= {op_a, op_b};
        end
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Dispatch FSM: pop/latch, start pulse, wait for ready low, then high.
    always_comb begin
        state_d      = state_q;
        mult_in_1_d  = mult_in_1_q;
        mult_in_2_d  = mult_in_2_q;
        mult_start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop_c) begin
                    mult_in_1_d  = head_c[ENTRY_W-1:WIDTH];
                    mult_in_2_d  = head_c[WIDTH-1:0];
                    mult_start_d = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // Ready still high here is the previous operation's level.
                if (!mult_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (mult_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result slot and completion counter; a capture beats a same-edge ack.
    always_comb begin
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        op_count_d  = op_count_q;
        if (capture_c) begin
            res_data_d  = mult_out;
            res_valid_d = 1'b1;
            op_count_d  = op_count_q + 8'd1;
        end else if (res_ack) begin
            res_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            mult_in_1_q  <= '0;
            mult_in_2_q  <= '0;
            mult_start_q <= 1'b0;
            res_data_q   <= '0;
            res_valid_q  <= 1'b0;
            op_count_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            mult_in_1_q  <= mult_in_1_d;
            mult_in_2_q  <= mult_in_2_d;
            mult_start_q <= mult_start_d;
            res_data_q   <= res_data_d;
            res_valid_q  <= res_valid_d;
            op_count_q   <= op_count_d;
        end
    end

    // Outputs; start is masked by rst so the shared multiplier never sees
    // a pulse while it is being reset.
    assign op_ready   = !full_c;
    assign mult_in_1  = mult_in_1_q;
    assign mult_in_2  = mult_in_2_q;
    assign mult_start = mult_start_q && !rst;
    assign res_data   = res_data_q;
    assign res_valid  = res_valid_q;
    assign op_count   = op_count_q;
    assign busy       = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_dispatcher.sv
// Bench for mult_dispatcher: a behavioural sequential-multiplier model with
// random latency, and a queue of expected products in push order.
module tb_mult_dispatcher;

    localparam int unsigned W = 4;
    localparam int unsigned D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           op_valid;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           op_ready;
    logic [W-1:0]   mult_in_1;
    logic [W-1:0]   mult_in_2;
    logic           mult_start;
    logic           mult_ready;
    logic [2*W-1:0] mult_out;
    logic [2*W-1:0] res_data;
    logic           res_valid;
    logic           res_ack;
    logic           busy;
    logic [7:0]     op_count;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int n_done   = 0;

    mult_dispatcher #(.DEPTH(D), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_ready   (op_ready),
        .mult_in_1  (mult_in_1),
        .mult_in_2  (mult_in_2),
        .mult_start (mult_start),
        .mult_ready (mult_ready),
        .mult_out   (mult_out),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ack    (res_ack),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    // Multiplier model: reacts 2 time units after each rising edge. Ready
    // falls 1..3 cycles after start, stays low 2..5 cycles with garbage on
    // the output, then rises with the true product.
    int m_phase = 0;
    int m_fall  = 0;
    int m_lat   = 0;
    int m_a     = 0;
    int m_b     = 0;
    initial begin
        mult_ready = 1'b1;
        mult_out   = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                checks++;
                if (mult_start !== 1'b0) begin
                    failures++;
                    $display("FAIL start_in_reset: got %0d expected 0", mult_start);
                end
                m_phase    = 0;
                mult_ready = 1'b1;
            end else if (m_phase == 0) begin
                if (mult_start === 1'b1) begin
                    m_a     = int'(mult_in_1);
                    m_b     = int'(mult_in_2);
                    m_fall  = $urandom_range(1, 3);
                    m_lat   = $urandom_range(2, 5);
                    m_phase = 1;
                end
            end else begin
                checks++;
                if (mult_start !== 1'b0 || int'(mult_in_1) != m_a || int'(mult_in_2) != m_b) begin
                    failures++;
                    $display("FAIL operand_hold: got start=%0d a=%0d b=%0d expected start=0 a=%0d b=%0d",
                             mult_start, mult_in_1, mult_in_2, m_a, m_b);
                end
                if (m_phase == 1) begin
                    m_fall--;
                    if (m_fall == 0) begin
                        mult_ready = 1'b0;
                        mult_out   = 8'($urandom);
                        m_phase    = 2;
                    end
                end else begin
                    m_lat--;
                    mult_out = 8'($urandom);
                    if (m_lat == 0) begin
                        mult_ready = 1'b1;
                        mult_out   = 8'(m_a * m_b);
                        m_phase    = 0;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time budget exhausted");
    end

    task automatic do_reset();
        rst      = 1'b1;
        op_valid = 1'b0;
        res_ack  = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        exp_q.delete();
        n_done = 0;
    endtask

    task automatic push(input int a, input int b);
        int g = 0;
        while (op_ready !== 1'b1 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: got op_ready=%0d expected 1", op_ready);
        end
        op_valid = 1'b1;
        op_a     = W'(a);
        op_b     = W'(b);
        exp_q.push_back(a * b);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int g = 0;
        while (res_valid !== 1'b1 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got res_valid=%0d expected 1", tag, res_valid);
        end
    endtask

    // Consumer: checks each result against the expected queue, then acks.
    task automatic collect(input int n, input int max_delay);
        int e;
        for (int i = 0; i < n; i++) begin
            wait_valid("collect");
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL extra_result: got %0d expected none", res_data);
            end else begin
                e = exp_q.pop_front();
                if (res_data !== 8'(e)) begin
                    failures++;
                    $display("FAIL result_data: got %0d expected %0d", res_data, 8'(e));
                end
            end
            n_done++;
            checks++;
            if (op_count !== 8'(n_done)) begin
                failures++;
                $display("FAIL op_count: got %0d expected %0d", op_count, 8'(n_done));
            end
            repeat ($urandom_range(0, max_delay)) @(negedge clk);
            res_ack = 1'b1;
            @(negedge clk);
            res_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        op_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        res_ack  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (op_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || op_count !== 8'd0 ||
            mult_start !== 1'b0 || mult_in_1 !== 4'd0 || mult_in_2 !== 4'd0 || res_data !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: got rdy=%0d busy=%0d rv=%0d cnt=%0d st=%0d a=%0d b=%0d rd=%0d expected 1 0 0 0 0 0 0 0",
                     op_ready, busy, res_valid, op_count, mult_start, mult_in_1, mult_in_2, res_data);
        end
    endtask

    task automatic test_single_op();
        do_reset();
        op_valid = 1'b1;
        op_a     = 4'd6;
        op_b     = 4'd9;
        @(negedge clk);
        op_valid = 1'b0;
        checks++;
        if (mult_start !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_after_push: got start=%0d busy=%0d expected 0 1", mult_start, busy);
        end
        @(negedge clk);
        checks++;
        if (mult_start !== 1'b1 || mult_in_1 !== 4'd6 || mult_in_2 !== 4'd9) begin
            failures++;
            $display("FAIL single_issue: got start=%0d a=%0d b=%0d expected 1 6 9", mult_start, mult_in_1, mult_in_2);
        end
        @(negedge clk);
        checks++;
        if (mult_start !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse_width: got %0d expected 0", mult_start);
        end
        wait_valid("single");
        checks++;
        if (res_data !== 8'd54 || op_count !== 8'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_result: got data=%0d cnt=%0d busy=%0d expected 54 1 0", res_data, op_count, busy);
        end
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_ack: got res_valid=%0d expected 0", res_valid);
        end
    endtask

    task automatic test_boundaries();
        do_reset();
        fork
            begin
                push(15, 15);
                push(0, 7);
                push(1, 1);
            end
            collect(3, 2);
        join
        checks++;
        if (op_count !== 8'd3) begin
            failures++;
            $display("FAIL boundary_count: got %0d expected 3", op_count);
        end
    endtask

    task automatic test_full_fifo();
        bit [5:0] rdy_seq;
        int a;
        int b;
        int e;
        do_reset();
        rdy_seq = 6'b011111;
        for (int i = 0; i < 6; i++) begin
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            op_valid = 1'b1;
            op_a     = W'(a);
            op_b     = W'(b);
            checks++;
            if (op_ready !== rdy_seq[i]) begin
                failures++;
                $display("FAIL full_ready_%0d: got %0d expected %0d", i, op_ready, rdy_seq[i]);
            end
            if (i < 5) exp_q.push_back(a * b);
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (op_ready !== 1'b0) begin
                failures++;
                $display("FAIL full_hold_ready: got %0d expected 0", op_ready);
            end
            @(negedge clk);
        end
        op_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_valid("full");
            e = exp_q.pop_front();
            n_done++;
            checks++;
            if (res_data !== 8'(e) || op_count !== 8'(n_done)) begin
                failures++;
                $display("FAIL full_result_%0d: got data=%0d cnt=%0d expected %0d %0d",
                         k, res_data, op_count, 8'(e), n_done);
            end
            res_ack = 1'b1;
            @(negedge clk);
            res_ack = 1'b0;
            checks++;
            if (res_valid !== 1'b0 || mult_start !== (k < 4) || op_ready !== 1'b1 || busy !== (k < 4)) begin
                failures++;
                $display("FAIL full_ack_%0d: got rv=%0d start=%0d rdy=%0d busy=%0d expected 0 %0d 1 %0d",
                         k, res_valid, mult_start, op_ready, busy, (k < 4), (k < 4));
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_rejected_stored: got rv=%0d busy=%0d expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int first;
        do_reset();
        push(2, 3);
        push(4, 5);
        first = exp_q[0];
        wait_valid("bp");
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mult_start !== 1'b0 || res_data !== 8'(first) || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold: got start=%0d data=%0d busy=%0d expected 0 %0d 1",
                         mult_start, res_data, busy, first);
            end
            @(negedge clk);
        end
        void'(exp_q.pop_front());
        n_done++;
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        checks++;
        if (mult_start !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: got start=%0d rv=%0d expected 1 0", mult_start, res_valid);
        end
        @(negedge clk);
        checks++;
        if (mult_start !== 1'b0) begin
            failures++;
            $display("FAIL bp_pulse_width: got %0d expected 0", mult_start);
        end
        collect(1, 0);
    endtask

    task automatic test_reset_mid();
        int g = 0;
        do_reset();
        push(7, 8);
        push(9, 10);
        push(11, 12);
        while (mult_ready !== 1'b0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        checks++;
        if (g >= 50 || mult_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_setup: got ready=%0d rv=%0d busy=%0d expected 0 0 1", mult_ready, res_valid, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mult_start !== 1'b0) begin
            failures++;
            $display("FAIL mid_start_in_reset: got %0d expected 0", mult_start);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        n_done = 0;
        checks++;
        if (op_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || op_count !== 8'd0) begin
            failures++;
            $display("FAIL mid_after_reset: got rdy=%0d busy=%0d rv=%0d cnt=%0d expected 1 0 0 0",
                     op_ready, busy, res_valid, op_count);
        end
        push(3, 5);
        collect(1, 0);
        repeat (10) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_abandoned: got rv=%0d busy=%0d expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        fork
            begin
                for (int a = 0; a < 16; a++) begin
                    for (int b = 0; b < 16; b++) begin
                        push(a, b);
                        repeat ($urandom_range(0, 1)) @(negedge clk);
                    end
                end
            end
            collect(256, 2);
        join
        checks++;
        if (op_count !== 8'd0) begin
            failures++;
            $display("FAIL wrap_count: got %0d expected 0", op_count);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_op();
        test_boundaries();
        test_full_fifo();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
